// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port (fetch, load/store) arbiter and sequencer in front of
// the shared data memory. Each access runs request -> single RAM cycle -> held
// response, and contended grants alternate between the two ports.
module dmem_arbiter #(
    parameter int IDX_LEN  = 64,
    parameter int DATA_LEN = 64
) (
    input  logic                clk,
    input  logic                rst,
    // instruction-fetch port
    input  logic                if_req_valid,
    output logic                if_req_ready,
    input  logic [IDX_LEN-1:0]  if_addr,
    output logic                if_resp_valid,
    input  logic                if_resp_ready,
    output logic [DATA_LEN-1:0] if_resp_data,
    // load/store port
    input  logic                ls_req_valid,
    output logic                ls_req_ready,
    input  logic                ls_we,
    input  logic [IDX_LEN-1:0]  ls_addr,
    input  logic [DATA_LEN-1:0] ls_wdata,
    input  logic [2:0]          ls_read_type,
    input  logic [1:0]          ls_write_type,
    output logic                ls_resp_valid,
    input  logic                ls_resp_ready,
    output logic [DATA_LEN-1:0] ls_resp_data,
    // RAM side
    output logic [IDX_LEN-1:0]  ram_idx,
    output logic [DATA_LEN-1:0] ram_w_data,
    output logic                ram_ren,
    output logic                ram_wen,
    output logic [2:0]          ram_read_type,
    output logic [1:0]          ram_write_type,
    input  logic [DATA_LEN-1:0] ram_r_data
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_RESP   = 2'd2;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    localparam logic [2:0] RT_LD  = 3'd3;
    localparam logic [2:0] RT_LWU = 3'd6;

    // The RAM has no type 7; treat it as a full-word load.
    function automatic logic [2:0] map_read_type(input logic [2:0] rt);
        logic [2:0] mapped;
        if (rt == 3'd7) begin
            mapped = RT_LD;
        end else begin
            mapped = rt;
        end
        return mapped;
    endfunction

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic                r_owner;
    logic                r_last_grant;
    logic                r_we;
    logic [IDX_LEN-1:0]  r_addr;
    logic [DATA_LEN-1:0] r_wdata;
    logic [2:0]          r_read_type;
    logic [1:0]          r_write_type;
    logic [DATA_LEN-1:0] r_if_resp_data;
    logic [DATA_LEN-1:0] r_ls_resp_data;

    logic                w_grant_valid;
    logic                w_grant;
    logic                w_owner_resp_ready;

    // Pick the winning requester in IDLE; ties go to the port not served last.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant       = OWN_IF;
        if (r_state == S_IDLE) begin
            if (if_req_valid && ls_req_valid) begin
                w_grant_valid = 1'b1;
                w_grant       = (r_last_grant == OWN_LS) ? OWN_IF : OWN_LS;
            end else if (if_req_valid) begin
                w_grant_valid = 1'b1;
                w_grant       = OWN_IF;
            end else if (ls_req_valid) begin
                w_grant_valid = 1'b1;
                w_grant       = OWN_LS;
            end else begin
                w_grant_valid = 1'b0;
                w_grant       = OWN_IF;
            end
        end else begin
            w_grant_valid = 1'b0;
            w_grant       = OWN_IF;
        end
    end

    assign if_req_ready       = w_grant_valid && (w_grant == OWN_IF);
    assign ls_req_ready       = w_grant_valid && (w_grant == OWN_LS);
    assign w_owner_resp_ready = (r_owner == OWN_IF) ? if_resp_ready : ls_resp_ready;

    // Sequencer next-state: IDLE -> ACCESS (one cycle) -> RESP until taken.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant_valid) begin
                    w_state_nxt = S_ACCESS;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ACCESS: begin
                w_state_nxt = S_RESP;
            end
            S_RESP: begin
                if (w_owner_resp_ready) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_RESP;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, request latches and response capture; reset aborts any access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_owner        <= OWN_IF;
            r_last_grant   <= OWN_LS;
            r_we           <= 1'b0;
            r_addr         <= {IDX_LEN{1'b0}};
            r_wdata        <= {DATA_LEN{1'b0}};
            r_read_type    <= 3'd0;
            r_write_type   <= 2'd0;
            r_if_resp_data <= {DATA_LEN{1'b0}};
            r_ls_resp_data <= {DATA_LEN{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            if (w_grant_valid) begin
                r_owner      <= w_grant;
                r_last_grant <= w_grant;
                if (w_grant == OWN_LS) begin
                    r_we         <= ls_we;
                    r_addr       <= ls_addr;
                    r_wdata      <= ls_wdata;
                    r_read_type  <= map_read_type(ls_read_type);
                    r_write_type <= ls_write_type;
                end else begin
                    r_we         <= 1'b0;
                    r_addr       <= if_addr;
                    r_read_type  <= RT_LWU;
                end
            end
            if (r_state == S_ACCESS) begin
                if (r_owner == OWN_IF) begin
                    r_if_resp_data <= {{(DATA_LEN-32){1'b0}}, ram_r_data[31:0]};
                end else if (r_we) begin
                    r_ls_resp_data <= {DATA_LEN{1'b0}};
                end else begin
                    r_ls_resp_data <= ram_r_data;
                end
            end
        end
    end

    assign ram_idx        = r_addr;
    assign ram_w_data     = r_wdata;
    assign ram_read_type  = r_read_type;
    assign ram_write_type = r_write_type;
    assign ram_ren        = (r_state == S_ACCESS);
    assign ram_wen        = (r_state == S_ACCESS) && (r_owner == OWN_LS) && r_we;

    assign if_resp_valid  = (r_state == S_RESP) && (r_owner == OWN_IF);
    assign ls_resp_valid  = (r_state == S_RESP) && (r_owner == OWN_LS);
    assign if_resp_data   = r_if_resp_data;
    assign ls_resp_data   = r_ls_resp_data;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench with a small word-indexed RAM behind the
// arbiter; expected values are hand-computed constants.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        if_req_valid, if_req_ready, if_resp_valid, if_resp_ready;
    logic [63:0] if_addr, if_resp_data;
    logic        ls_req_valid, ls_req_ready, ls_we, ls_resp_valid, ls_resp_ready;
    logic [63:0] ls_addr, ls_wdata, ls_resp_data;
    logic [2:0]  ls_read_type;
    logic [1:0]  ls_write_type;
    logic [63:0] ram_idx, ram_w_data, ram_r_data;
    logic        ram_ren, ram_wen;
    logic [2:0]  ram_read_type;
    logic [1:0]  ram_write_type;

    int n_checks = 0;
    int n_errors = 0;
    int wen_cnt  = 0;

    logic [63:0] mem [0:15];

    dmem_arbiter #(.IDX_LEN(64), .DATA_LEN(64)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_addr(if_addr),
        .if_resp_valid(if_resp_valid), .if_resp_ready(if_resp_ready), .if_resp_data(if_resp_data),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_we(ls_we),
        .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_read_type(ls_read_type),
        .ls_write_type(ls_write_type), .ls_resp_valid(ls_resp_valid),
        .ls_resp_ready(ls_resp_ready), .ls_resp_data(ls_resp_data),
        .ram_idx(ram_idx), .ram_w_data(ram_w_data), .ram_ren(ram_ren), .ram_wen(ram_wen),
        .ram_read_type(ram_read_type), .ram_write_type(ram_write_type), .ram_r_data(ram_r_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM read path: sign/zero extension by read type.
    function automatic logic [63:0] ram_rd(input logic [63:0] w, input logic [2:0] t);
        case (t)
            3'd0:    return {{56{w[7]}}, w[7:0]};
            3'd1:    return {{48{w[15]}}, w[15:0]};
            3'd2:    return {{32{w[31]}}, w[31:0]};
            3'd3:    return w;
            3'd4:    return {56'd0, w[7:0]};
            3'd5:    return {48'd0, w[15:0]};
            3'd6:    return {32'd0, w[31:0]};
            default: return 64'hBAD0_BAD0_BAD0_BAD0;
        endcase
    endfunction

    // Combinational RAM read.
    always_comb begin
        ram_r_data = 64'd0;
        if (ram_ren) ram_r_data = ram_rd(mem[ram_idx[3:0]], ram_read_type);
    end

    // RAM write with sub-word merge into the low bits of the word.
    always @(posedge clk) begin
        if (ram_wen) begin
            case (ram_write_type)
                2'd0:    mem[ram_idx[3:0]][7:0]  <= ram_w_data[7:0];
                2'd1:    mem[ram_idx[3:0]][15:0] <= ram_w_data[15:0];
                2'd2:    mem[ram_idx[3:0]][31:0] <= ram_w_data[31:0];
                default: mem[ram_idx[3:0]]       <= ram_w_data;
            endcase
        end
    end

    // Count cycles in which a RAM write is issued.
    always @(negedge clk) begin
        if (ram_wen) wen_cnt <= wen_cnt + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        if_req_valid = 1'b0; if_resp_ready = 1'b0; if_addr = 64'd0;
        ls_req_valid = 1'b0; ls_resp_ready = 1'b0; ls_we = 1'b0;
        ls_addr = 64'd0; ls_wdata = 64'd0; ls_read_type = 3'd0; ls_write_type = 2'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic if_txn(input string tag, input logic [63:0] addr, input logic [63:0] exp);
        @(posedge clk); #1;
        if_req_valid = 1'b1; if_addr = addr;
        @(negedge clk);
        for (int k = 0; k < 20 && !if_req_ready; k++) @(negedge clk);
        check({tag, "_req_ready"}, 64'(if_req_ready), 64'd1);
        @(posedge clk); #1;
        if_req_valid = 1'b0;
        @(negedge clk);
        check({tag, "_ram_ren"}, 64'(ram_ren), 64'd1);
        check({tag, "_ram_rtype"}, 64'(ram_read_type), 64'd6);
        @(negedge clk);
        check({tag, "_resp_valid"}, 64'(if_resp_valid), 64'd1);
        check({tag, "_resp_data"}, if_resp_data, exp);
        if_resp_ready = 1'b1;
        @(posedge clk); #1;
        if_resp_ready = 1'b0;
    endtask

    task automatic ls_txn(input string tag, input logic we, input logic [63:0] addr,
                          input logic [63:0] wd, input logic [2:0] rt, input logic [1:0] wt,
                          input logic [2:0] rt_exp, input logic [63:0] exp);
        @(posedge clk); #1;
        ls_req_valid = 1'b1; ls_we = we; ls_addr = addr; ls_wdata = wd;
        ls_read_type = rt; ls_write_type = wt;
        @(negedge clk);
        for (int k = 0; k < 20 && !ls_req_ready; k++) @(negedge clk);
        check({tag, "_req_ready"}, 64'(ls_req_ready), 64'd1);
        @(posedge clk); #1;
        ls_req_valid = 1'b0;
        @(negedge clk);
        check({tag, "_ram_idx"}, ram_idx, addr);
        check({tag, "_ram_wen"}, 64'(ram_wen), 64'(we));
        check({tag, "_ram_rtype"}, 64'(ram_read_type), 64'(rt_exp));
        @(negedge clk);
        check({tag, "_resp_valid"}, 64'(ls_resp_valid), 64'd1);
        check({tag, "_if_resp_valid"}, 64'(if_resp_valid), 64'd0);
        check({tag, "_resp_data"}, ls_resp_data, exp);
        ls_resp_ready = 1'b1;
        @(posedge clk); #1;
        ls_resp_ready = 1'b0;
    endtask

    int grants [0:5];
    int gcyc   [0:5];
    int n_grants;
    int dual;
    int wen_before;
    int late_valid;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] <= 64'd0;
        do_reset();

        // reset state
        @(negedge clk);
        check("rst_if_req_ready", 64'(if_req_ready), 64'd0);
        check("rst_ls_req_ready", 64'(ls_req_ready), 64'd0);
        check("rst_resp_valids", {62'd0, if_resp_valid, ls_resp_valid}, 64'd0);
        check("rst_ram_en", {62'd0, ram_ren, ram_wen}, 64'd0);
        check("rst_ram_idx", ram_idx, 64'd0);
        check("rst_ram_types", {59'd0, ram_read_type, ram_write_type}, 64'd0);

        // fetch only
        mem[5] <= 64'hFFFF_FFFF_8000_0013;
        mem[2] <= 64'h0000_0000_0000_0080;
        mem[3] <= 64'h1122_3344_5566_7788;
        mem[7] <= 64'h0123_4567_89AB_CDEF;
        mem[9] <= 64'h5555_6666_7777_8888;
        wen_before = wen_cnt;
        if_txn("fetch5", 64'd5, 64'h0000_0000_8000_0013);
        check("fetch_no_wen", 64'(wen_cnt - wen_before), 64'd0);

        // load types
        ls_txn("lb", 1'b0, 64'd2, 64'd0, 3'd0, 2'd0, 3'd0, 64'hFFFF_FFFF_FFFF_FF80);
        ls_txn("lbu", 1'b0, 64'd2, 64'd0, 3'd4, 2'd0, 3'd4, 64'h0000_0000_0000_0080);
        ls_txn("lt7", 1'b0, 64'd2, 64'd0, 3'd7, 2'd0, 3'd3, 64'h0000_0000_0000_0080);

        // store merge
        ls_txn("sh", 1'b1, 64'd3, 64'hAAAA_BBBB_CCCC_DDEE, 3'd3, 2'd1, 3'd3, 64'd0);
        ls_txn("ld3", 1'b0, 64'd3, 64'd0, 3'd3, 2'd0, 3'd3, 64'h1122_3344_5566_DDEE);

        // contention after reset: if, ls, if, ls, if, ls at 3-cycle spacing
        do_reset();
        @(posedge clk); #1;
        if_req_valid = 1'b1; if_addr = 64'd5; if_resp_ready = 1'b1;
        ls_req_valid = 1'b1; ls_we = 1'b0; ls_addr = 64'd2; ls_read_type = 3'd3; ls_resp_ready = 1'b1;
        n_grants = 0;
        dual = 0;
        for (int c = 0; c < 60 && n_grants < 6; c++) begin
            @(negedge clk);
            if (if_req_ready && ls_req_ready) dual++;
            if (if_req_ready) begin
                grants[n_grants] = 0; gcyc[n_grants] = c; n_grants++;
            end else if (ls_req_ready) begin
                grants[n_grants] = 1; gcyc[n_grants] = c; n_grants++;
            end
        end
        @(posedge clk); #1;
        if_req_valid = 1'b0; ls_req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        if_resp_ready = 1'b0; ls_resp_ready = 1'b0;
        check("grant_count", 64'(n_grants), 64'd6);
        for (int i = 0; i < 6; i++) check($sformatf("grant%0d_port", i), 64'(grants[i]), 64'(i % 2));
        check("grant_gap", 64'(gcyc[1] - gcyc[0]), 64'd3);
        check("dual_ready", 64'(dual), 64'd0);

        // back-pressure on a load, fetch waiting
        @(posedge clk); #1;
        ls_req_valid = 1'b1; ls_we = 1'b0; ls_addr = 64'd7; ls_read_type = 3'd3;
        @(negedge clk);
        check("bp_ls_ready", 64'(ls_req_ready), 64'd1);
        @(posedge clk); #1;
        ls_req_valid = 1'b0; if_req_valid = 1'b1; if_addr = 64'd5;
        @(negedge clk);
        check("bp_access_if_ready", 64'(if_req_ready), 64'd0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp_valid%0d", i), 64'(ls_resp_valid), 64'd1);
            check($sformatf("bp_data%0d", i), ls_resp_data, 64'h0123_4567_89AB_CDEF);
            check($sformatf("bp_if_ready%0d", i), 64'(if_req_ready), 64'd0);
            @(negedge clk);
        end
        ls_resp_ready = 1'b1;
        @(posedge clk); #1;
        ls_resp_ready = 1'b0;
        @(negedge clk);
        check("bp_if_ready_after", 64'(if_req_ready), 64'd1);
        check("bp_ls_valid_after", 64'(ls_resp_valid), 64'd0);
        @(posedge clk); #1;
        if_req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("bp_fetch_valid", 64'(if_resp_valid), 64'd1);
        check("bp_fetch_data", if_resp_data, 64'h0000_0000_8000_0013);
        if_resp_ready = 1'b1;
        @(posedge clk); #1;
        if_resp_ready = 1'b0;

        // reset in the ACCESS cycle of an sd
        @(posedge clk); #1;
        ls_req_valid = 1'b1; ls_we = 1'b1; ls_addr = 64'd9;
        ls_wdata = 64'hAAAA_BBBB_CCCC_DDDD; ls_write_type = 2'd3; ls_read_type = 3'd3;
        @(negedge clk);
        check("rs_ls_ready", 64'(ls_req_ready), 64'd1);
        @(posedge clk); #1;
        ls_req_valid = 1'b0;
        @(negedge clk);
        check("rs_wen_in_access", 64'(ram_wen), 64'd1);
        rst = 1'b1;
        #1;
        check("rs_async_en", {62'd0, ram_ren, ram_wen}, 64'd0);
        check("rs_async_idx", ram_idx, 64'd0);
        check("rs_async_wdata", ram_w_data, 64'd0);
        check("rs_async_types", {59'd0, ram_read_type, ram_write_type}, 64'd0);
        check("rs_async_ls_data", ls_resp_data, 64'd0);
        check("rs_async_if_data", if_resp_data, 64'd0);
        check("rs_async_valids", {62'd0, if_resp_valid, ls_resp_valid}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        late_valid = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (if_resp_valid || ls_resp_valid) late_valid++;
        end
        check("rs_no_resp_valid", 64'(late_valid), 64'd0);
        check("rs_mem_unchanged", mem[9], 64'h5555_6666_7777_8888);
        ls_txn("rs_ld9", 1'b0, 64'd9, 64'd0, 3'd3, 2'd0, 3'd3, 64'h5555_6666_7777_8888);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

- Two-requester arbiter and sequencer in front of the shared data-memory block (ram_top).
- Requesters:
  - Instruction-fetch port (read-only).
  - Load/store port (reads and sub-word writes).
- One access runs at a time, in three phases: registered request, single-cycle RAM access, held response.
- Round-robin fairness when both requesters contend.

## Interface
Parameters:
- IDX_LEN, 64, width of request addresses and of the RAM index.
- DATA_LEN, 64, width of data words.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- if_req_valid  input  1  fetch request present.
- if_req_ready  output  1  fetch request accepted this cycle.
- if_addr  input  IDX_LEN  fetch word index.
- if_resp_valid  output  1  fetch data available.
- if_resp_ready  input  1  fetch consumer takes the response.
- if_resp_data  output  DATA_LEN  fetch data, zero-extended low 32 bits.
- ls_req_valid  input  1  load/store request present.
- ls_req_ready  output  1  load/store request accepted this cycle.
- ls_we  input  1  1 = store, 0 = load.
- ls_addr  input  IDX_LEN  load/store word index.
- ls_wdata  input  DATA_LEN  store data.
- ls_read_type  input  3  load type: 0 lb, 1 lh, 2 lw, 3 ld, 4 lbu, 5 lhu, 6 lwu.
- ls_write_type  input  2  store type: 0 sb, 1 sh, 2 sw, 3 sd.
- ls_resp_valid  output  1  load data or store acknowledge available.
- ls_resp_ready  input  1  load/store consumer takes the response.
- ls_resp_data  output  DATA_LEN  load result; 0 for stores.
- ram_idx  output  IDX_LEN  to the RAM index port.
- ram_w_data  output  DATA_LEN  to the RAM write-data port.
- ram_ren  output  1  RAM read enable.
- ram_wen  output  1  RAM write enable.
- ram_read_type  output  3  RAM read type.
- ram_write_type  output  2  RAM write type.
- ram_r_data  input  DATA_LEN  RAM read data; combinational from ram_idx and ram_ren.

## Operation
State machine: IDLE, ACCESS, RESP.

IDLE:
- Grant selection:
  - Only one valid requester: that requester wins.
  - Both valid: the requester not equal to last_grant wins.
- The winner's req_ready is 1; the loser's req_ready is 0.
- req_ready is 0 in every state other than IDLE.
- On acceptance:
  - Latch owner, addr, we, wdata, read_type and write_type.
  - Update last_grant to the owner.
  - Go to ACCESS.

ACCESS (always exactly one cycle):
- ram_idx = latched addr.
- Fetch owner:
  - ram_ren = 1, ram_read_type = 6.
  - ram_r_data is captured into the response register.
- Load owner:
  - ram_ren = 1, ram_read_type = latched type.
  - A type of 7 is forwarded as 3.
  - ram_r_data is captured into the response register.
- Store owner:
  - ram_ren = 1 (the merge needs old data), ram_wen = 1.
  - ram_write_type = latched type, ram_w_data = latched wdata.
  - The response register is cleared to 0.
- Go to RESP.

RESP:
- The owner's resp_valid is 1; resp_data is held stable.
- When the owner's resp_ready is 1: go to IDLE.

General rules:
- The non-owner's resp_valid is always 0.
- Outside ACCESS: ram_ren = ram_wen = 0. ram_idx, ram_w_data, ram_read_type and ram_write_type hold their last values.
- Requests are never dropped or reordered per port.

## Timing
Reset:
- state = IDLE, last_grant = ls. Fetch therefore wins the first contended grant.
- All req_ready, resp_valid, ram_ren and ram_wen are 0, except that the combinational IDLE grant may raise req_ready.
- All data, index and type outputs are 0.
- A reset during ACCESS or RESP aborts the operation:
  - No ram_wen is issued after reset assertion.
  - The pending response is discarded.

Latency:
- Request accepted at edge N.
- ACCESS during cycle N+1; any write commits at edge N+2.
- resp_valid is 1 from cycle N+2.
- The earliest next acceptance is the cycle after the response handshake, so sustained throughput is 1 access per 3 cycles.

Edge cases:
- A requester may drop valid before ready with no effect.
- Back-pressure (resp_ready = 0) holds RESP indefinitely and blocks both ports.
- A request arriving during ACCESS or RESP waits, with ready = 0.

## Test plan
- Fetch only: ram[5] = 0xFFFF_FFFF_8000_0013, fetch addr 5.
  - Required: if_resp_valid at N+2 with data 0x0000_0000_8000_0013.
  - Required: ram_wen never asserted.
- Load types: ram[2] = 0x0000_0000_0000_0080.
  - lb at addr 2 returns 0xFFFF_FFFF_FFFF_FF80.
  - lbu at addr 2 returns 0x80.
  - read_type 7 returns the full word 0x80.
- Store merge: ram[3] = 0x1122_3344_5566_7788; sh with wdata 0xAAAA_BBBB_CCCC_DDEE.
  - Required: ls_resp_valid with data 0.
  - Required: a later ld at addr 3 returns 0x1122_3344_5566_DDEE.
- Contention: both valid continuously for 6 accesses after reset.
  - Required grant order: if, ls, if, ls, if, ls.
  - Required: no port is accepted twice in a row while the other is valid.
- Back-pressure: hold ls_resp_ready = 0 for 5 cycles after a load.
  - Required: ls_resp_valid and ls_resp_data stay stable.
  - Required: if_req_ready stays 0.
  - Required: the fetch is accepted in the cycle after the ready handshake.
- Reset mid-store: assert rst during ACCESS of an sd.
  - Required: all outputs return to their reset values asynchronously.
  - Required: after reset, ram ready responses show the old word unchanged where the wen edge was suppressed.
  - Required: no resp_valid appears.
